// File: rtl/tanh_arb_pkg.sv
// Shared definitions for the tanh LUT arbiter.
//   TANH_LATENCY : enabled-clock latency of the shared tanh pipeline
//   F32_ONE      : fp32 encoding of +1.0 (saturated tanh magnitude)
//   TAG_IDW      : id field width held in every tag (covers up to 16 requesters)
//   tag_t        : per-stage tag {valid, requester id}
package tanh_arb_pkg;

  localparam int unsigned TANH_LATENCY = 4;
  localparam logic [31:0] F32_ONE      = 32'h3F800000;
  localparam int unsigned TAG_IDW      = 4;

  typedef struct packed {
    logic               v;
    logic [TAG_IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req    in  N    request vector
//   ptr    in  IDW  highest-priority index for this cycle
//   gnt    out N    one-hot grant, zero when no request
//   gnt_id out IDW  index of the granted request (0 when none)
module rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id
);

  always_comb begin
    logic found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    // Walk from ptr upward, wrapping at N-1, and take the first active request.
    for (int unsigned off = 0; off < N; off++) begin
      int unsigned idx;
      idx = (32'(ptr) + off) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tanh_lut_arbiter.sv
// Shares one tanh LUT pipeline between N_REQ requesters.
// A round-robin arbiter accepts at most one request per cycle, a tag shift register follows each
// operand through the pipeline, and results are returned with their requester id. Backpressure on
// the result port freezes the pipeline, the tags and the arbitration pointer.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_data   per-requester request and 16-bit operand (slice i = [16*i +: 16])
//   req_ready            per-requester accept (one-hot or zero)
//   rsp_valid/rsp_data   result valid and fp32 result
//   rsp_id/rsp_ready     requester id of the result, downstream accept
//   pipe_en/pipe_din     pipeline enable and operand
//   pipe_dout            pipeline result
//   busy                 at least one valid tag in flight
module tanh_lut_arbiter
  import tanh_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned LATENCY = TANH_LATENCY,
  parameter int unsigned IDW     = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [16*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                rsp_valid,
  output logic [31:0]         rsp_data,
  output logic [IDW-1:0]      rsp_id,
  input  logic                rsp_ready,
  output logic                pipe_en,
  output logic [15:0]         pipe_din,
  input  logic [31:0]         pipe_dout,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  tag_t             tag_q [LATENCY];

  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_id;
  logic             transfer;
  logic             consume;

  rr_arbiter #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Stall only when a valid head result is refused; an invalid head never blocks.
  assign rsp_valid = tag_q[LATENCY-1].v;
  assign rsp_id    = tag_q[LATENCY-1].id[IDW-1:0];
  assign rsp_data  = pipe_dout;
  assign consume   = rsp_valid & rsp_ready;
  assign pipe_en   = rst_n & ~(rsp_valid & ~rsp_ready);
  assign req_ready = gnt & {N_REQ{pipe_en}};
  assign transfer  = |(req_valid & req_ready);
  assign busy      = (inflight_q != '0);

  // Upper id bits exist only for wide configurations.
  logic unused_id;
  assign unused_id = ^tag_q[LATENCY-1].id;

  always_comb begin
    pipe_din = 16'h0000;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        pipe_din = req_data[16*i +: 16];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (transfer) begin
      rr_ptr_d = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (transfer && !consume) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!transfer && consume) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      inflight_q <= '0;
      for (int unsigned s = 0; s < LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      inflight_q <= inflight_d;
      if (pipe_en) begin
        rr_ptr_q <= rr_ptr_d;
        tag_q[0] <= '{v: transfer, id: TAG_IDW'(gnt_id)};
        for (int unsigned s = 1; s < LATENCY; s++) begin
          tag_q[s] <= tag_q[s-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_tanh_lut_arbiter.sv
module tb_tanh_lut_arbiter;

  localparam int unsigned NReq = 4;
  localparam int unsigned Lat  = 4;
  localparam int unsigned Idw  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NReq-1:0]     req_valid = '0;
  logic [16*NReq-1:0]  req_data = '0;
  logic [NReq-1:0]     req_ready;
  logic                rsp_valid;
  logic [31:0]         rsp_data;
  logic [Idw-1:0]      rsp_id;
  logic                rsp_ready = 1'b1;
  logic                pipe_en;
  logic [15:0]         pipe_din;
  logic [31:0]         pipe_dout;
  logic                busy;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [Idw-1:0] id;
    logic [31:0]    data;
  } exp_t;

  exp_t           sb[$];
  logic [Idw-1:0] model_ptr = '0;
  logic [31:0]    pipe_st [Lat];

  always #5 clk = ~clk;

  tanh_lut_arbiter #(
    .N_REQ   (NReq),
    .LATENCY (Lat)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .pipe_en   (pipe_en),
    .pipe_din  (pipe_din),
    .pipe_dout (pipe_dout),
    .busy      (busy)
  );

  // Stand-in for the shared LUT: saturates to +/-1.0 for |x| >= 2.0, otherwise a unique tag of x.
  function automatic logic [31:0] tanh_model(input logic [15:0] x);
    if (x[14:10] >= 5'd16) return x[15] ? 32'hBF800000 : 32'h3F800000;
    return {x[15], 15'h1F00, x};
  endfunction

  // Pipeline model: no reset, advances only on pipe_en.
  always @(posedge clk) begin
    if (pipe_en) begin
      pipe_st[0] <= tanh_model(pipe_din);
      for (int s = 1; s < Lat; s++) pipe_st[s] <= pipe_st[s-1];
    end
  end
  assign pipe_dout = pipe_st[Lat-1];

  // Record every accepted request as an expected result.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_ptr <= '0;
    end else begin
      for (int i = 0; i < NReq; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{id: Idw'(i), data: tanh_model(req_data[16*i +: 16])});
          model_ptr <= Idw'((i + 1) % NReq);
        end
      end
    end
  end

  task automatic test_reset;
    req_valid = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (req_ready !== '0) begin failures++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    if (pipe_en !== 1'b0) begin failures++; $display("FAIL rst_pipe_en: got %b want 0", pipe_en); end
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single(input logic [15:0] x, input logic [31:0] want);
    exp_t e;
    int   lat;
    @(posedge clk); #1;
    req_valid = 4'b0001;
    req_data[15:0] = x;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    checks += 3;
    if (lat !== 4) begin failures++; $display("FAIL single_latency: got %0d want 4", lat); end
    if (rsp_data !== want) begin failures++; $display("FAIL single_data: got %h want %h", rsp_data, want); end
    if (rsp_id !== 2'd0) begin failures++; $display("FAIL single_id: got %0d want 0", rsp_id); end
    if (rsp_valid && rsp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL single_sb: unexpected result id=%0d data=%h", rsp_id, rsp_data);
      end else begin
        e = sb.pop_front();
        if (rsp_id !== e.id || rsp_data !== e.data) begin
          failures++;
          $display("FAIL single_sb: got id=%0d data=%h want id=%0d data=%h", rsp_id, rsp_data, e.id, e.data);
        end
      end
    end
  endtask

  task automatic test_reset_midflight;
    exp_t e;
    int   nrsp;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 4'b0111;
    req_data  = {16'h0000, 16'h3222, 16'h3111, 16'h3000};
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    req_valid = '0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    #1;
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    checks += 3;
    if (req_ready !== '0) begin failures++; $display("FAIL mid_ready: got %b want 0", req_ready); end
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_rsp_valid: got %b want 0", rsp_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b want 0", busy); end
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL mid_ptr_reset: got %b want 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    nrsp = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        nrsp++;
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL mid_sb: stale result id=%0d data=%h", rsp_id, rsp_data);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_data !== e.data) begin
            failures++;
            $display("FAIL mid_sb: got id=%0d data=%h want id=%0d data=%h", rsp_id, rsp_data, e.id, e.data);
          end
        end
      end
    end
    checks += 2;
    if (nrsp !== 1) begin failures++; $display("FAIL mid_count: got %0d results want 1", nrsp); end
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy_after: got %b want 0", busy); end
  endtask

  task automatic drain(input string name);
    exp_t e;
    int   n;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL %s_drain: unexpected result id=%0d data=%h", name, rsp_id, rsp_data);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_data !== e.data) begin
            failures++;
            $display("FAIL %s_drain: got id=%0d data=%h want id=%0d data=%h",
                     name, rsp_id, rsp_data, e.id, e.data);
          end
        end
      end
      if (sb.size() == 0 && !busy) break;
    end
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s_drain_end: %0d results missing busy=%b want 0", name, sb.size(), busy);
    end
  endtask

  task automatic test_all_saturated;
    exp_t           e;
    logic [Idw-1:0] start;
    logic [NReq-1:0] want;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    start = model_ptr;
    for (int i = 0; i < NReq; i++) req_data[16*i +: 16] = 16'h3000 + 16'(i * 16'h111);
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      want = NReq'(1) << ((int'(start) + k) % NReq);
      checks++;
      if (req_ready !== want) begin
        failures++; $display("FAIL sat_grant[%0d]: got %b want %b", k, req_ready, want);
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL sat_sb: unexpected result id=%0d data=%h", rsp_id, rsp_data);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_data !== e.data) begin
            failures++;
            $display("FAIL sat_sb: got id=%0d data=%h want id=%0d data=%h", rsp_id, rsp_data, e.id, e.data);
          end
        end
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    drain("sat");
  endtask

  task automatic test_backpressure;
    logic [31:0]    d0;
    logic [Idw-1:0] id0;
    int             n;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 4'b0100;
    req_data[47:32] = 16'h3123;
    @(negedge clk);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    req_data[15:0] = 16'h2abc;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    checks += 2;
    if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_timeout: rsp_valid got %b want 1", rsp_valid); end
    if (rsp_id !== 2'd2) begin failures++; $display("FAIL bp_id: got %0d want 2", rsp_id); end
    d0  = rsp_data;
    id0 = rsp_id;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_id !== id0 || req_ready !== '0 ||
          pipe_en !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: v=%b data=%h id=%0d ready=%b en=%b want v=1 data=%h id=%0d ready=0 en=0",
                 k, rsp_valid, rsp_data, rsp_id, req_ready, pipe_en, d0, id0);
      end
      if (k < 4) @(negedge clk);
    end
    checks++;
    if (sb.size() != 4) begin failures++; $display("FAIL bp_inflight: got %0d queued want 4", sb.size()); end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = '0;
    drain("bp");
  endtask

  task automatic test_bubbles;
    exp_t e;
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      req_valid = {2'b00, k[0], 1'b0};
      req_data[31:16] = 16'h2000 + 16'(k);
      @(negedge clk);
      checks += 2;
      if (req_ready !== {2'b00, k[0], 1'b0}) begin
        failures++; $display("FAIL bub_ready[%0d]: got %b want %b", k, req_ready, {2'b00, k[0], 1'b0});
      end
      if (dut.inflight_q > 4) begin
        failures++; $display("FAIL bub_inflight[%0d]: got %0d want <=4", k, dut.inflight_q);
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL bub_sb: bubble reported id=%0d data=%h", rsp_id, rsp_data);
        end else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_data !== e.data) begin
            failures++;
            $display("FAIL bub_sb: got id=%0d data=%h want id=%0d data=%h", rsp_id, rsp_data, e.id, e.data);
          end
        end
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    drain("bub");
  endtask

  initial begin
    test_reset();
    test_single(16'h4200, 32'h3F800000);
    test_single(16'hC200, 32'hBF800000);
    test_reset_midflight();
    test_all_saturated();
    test_backpressure();
    test_bubbles();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
